// File: rtl/fetch_stage_if.sv
// Instruction-fetch interface bundle: instruction-memory request/response,
// decode-side IF/ID outputs and execute-side stall/redirect controls.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        misalign;

  modport master (
    output imem_req, imem_addr, inst, pc, pc_plus4, inst_valid, misalign,
    input  imem_rvalid, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst, pc, pc_plus4, inst_valid, misalign,
    output imem_rvalid, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: single-outstanding imem requests, one-entry skid, IF/ID register.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHK_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_START | idle, no request (after reset, or parked on a misaligned pc)
// ST_ISSUE | drive imem_req for pc_q, advance pc_q
// ST_WAIT  | one request in flight, waiting for imem_rvalid
// ST_HOLD  | response parked in skid until decode releases stall
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master fif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        inst_valid_q, inst_valid_d;
  logic        misalign_q, misalign_d;

  logic        imem_req;
  logic        ifid_free;
  logic [31:0] rd_pc;
  logic        rd_misalign;
  state_t      rd_resume;
  state_t      kill_resume;

`ifdef FETCH_MISALIGN_CHK_EN
  assign rd_pc       = fif.redirect_pc;
  assign rd_misalign = |fif.redirect_pc[1:0];
`else
  assign rd_pc       = fif.redirect_pc & 32'hFFFF_FFFC;
  assign rd_misalign = 1'b0;
`endif

  assign ifid_free   = !inst_valid_q || !fif.stall;
  // A misaligned target parks the FSM in START until an aligned redirect arrives.
  assign rd_resume   = rd_misalign ? ST_START : ST_ISSUE;
  assign kill_resume = misalign_q  ? ST_START : ST_ISSUE;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    kill_d       = kill_q;
    inst_d       = inst_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    inst_valid_d = inst_valid_q;
    misalign_d   = misalign_q;
    imem_req     = (state_q == ST_ISSUE);

    if (inst_valid_q && !fif.stall) begin
      inst_valid_d = 1'b0;
    end

    if (fif.redirect) begin
      pc_d         = rd_pc;
      inst_valid_d = 1'b0;
      misalign_d   = rd_misalign;
      case (state_q)
        ST_ISSUE: begin
          req_pc_d = pc_q;
          kill_d   = 1'b1;
          state_d  = ST_WAIT;
        end
        ST_WAIT: begin
          if (fif.imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = rd_resume;
          end else begin
            kill_d  = 1'b1;
          end
        end
        default: begin
          state_d = rd_resume;
        end
      endcase
    end else begin
      case (state_q)
        ST_START: begin
          if (!misalign_q) begin
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = ST_WAIT;
        end
        ST_WAIT: begin
          if (fif.imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = kill_resume;
            end else if (ifid_free) begin
              inst_d       = fif.imem_rdata;
              id_pc_d      = req_pc_q;
              id_pc4_d     = req_pc_q + 32'd4;
              inst_valid_d = 1'b1;
              state_d      = ST_ISSUE;
            end else begin
              skid_inst_d = fif.imem_rdata;
              skid_pc_d   = req_pc_q;
              state_d     = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!fif.stall) begin
            inst_d       = skid_inst_q;
            id_pc_d      = skid_pc_q;
            id_pc4_d     = skid_pc_q + 32'd4;
            inst_valid_d = 1'b1;
            state_d      = ST_ISSUE;
          end
        end
        default: begin
          state_d = ST_START;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_START;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      skid_inst_q  <= NOP;
      skid_pc_q    <= 32'd0;
      kill_q       <= 1'b0;
      inst_q       <= NOP;
      id_pc_q      <= 32'd0;
      id_pc4_q     <= 32'd0;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      kill_q       <= kill_d;
      inst_q       <= inst_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
      inst_valid_q <= inst_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  assign fif.imem_req   = imem_req;
  assign fif.imem_addr  = pc_q;
  assign fif.inst       = inst_q;
  assign fif.pc         = id_pc_q;
  assign fif.pc_plus4   = id_pc4_q;
  assign fif.inst_valid = inst_valid_q;
  assign fif.misalign   = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable instruction memory model.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int unsigned mem_lat;

  logic        mem_busy;
  int unsigned mem_cnt;
  logic [31:0] mem_addr;

  fetch_stage_if fif ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fif.imem_rvalid <= 1'b0;
      fif.imem_rdata  <= 32'd0;
      mem_busy        <= 1'b0;
      mem_cnt         <= 0;
      mem_addr        <= 32'd0;
    end else begin
      fif.imem_rvalid <= 1'b0;
      if (mem_busy) begin
        if (mem_cnt == 1) begin
          fif.imem_rvalid <= 1'b1;
          fif.imem_rdata  <= word_of(mem_addr);
          mem_busy        <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
      if (fif.imem_req) begin
        if (mem_lat <= 1) begin
          fif.imem_rvalid <= 1'b1;
          fif.imem_rdata  <= word_of(fif.imem_addr);
        end else begin
          mem_busy <= 1'b1;
          mem_cnt  <= mem_lat - 1;
          mem_addr <= fif.imem_addr;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic do_reset(input int unsigned lat);
    rst_n           = 1'b0;
    fif.stall       = 1'b0;
    fif.redirect    = 1'b0;
    fif.redirect_pc = 32'd0;
    mem_lat         = lat;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n           = 1'b0;
    fif.stall       = 1'b0;
    fif.redirect    = 1'b0;
    fif.redirect_pc = 32'd0;
    mem_lat         = 1;
    @(negedge clk);
    total++; if (fif.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", fif.imem_req); end
    total++; if (fif.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 00000000", fif.imem_addr); end
    total++; if (fif.inst !== 32'h13) begin bad++; $display("FAIL reset_inst: got %h want 00000013", fif.inst); end
    total++; if (fif.pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 00000000", fif.pc); end
    total++; if (fif.pc_plus4 !== 32'h0) begin bad++; $display("FAIL reset_pc4: got %h want 00000000", fif.pc_plus4); end
    total++; if (fif.inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", fif.inst_valid); end
    total++; if (fif.misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign: got %b want 0", fif.misalign); end
  endtask

  task automatic test_stream;
    logic        e_req   [7];
    logic [31:0] e_addr  [7];
    logic        e_valid [7];
    logic [31:0] e_pc    [7];
    e_req   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    e_addr  = '{32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'h0, 32'hC};
    e_valid = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    e_pc    = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8};
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++; if (fif.imem_req !== e_req[i]) begin bad++; $display("FAIL stream_req[%0d]: got %b want %b", i, fif.imem_req, e_req[i]); end
      if (e_req[i]) begin
        total++; if (fif.imem_addr !== e_addr[i]) begin bad++; $display("FAIL stream_addr[%0d]: got %h want %h", i, fif.imem_addr, e_addr[i]); end
      end
      total++; if (fif.inst_valid !== e_valid[i]) begin bad++; $display("FAIL stream_valid[%0d]: got %b want %b", i, fif.inst_valid, e_valid[i]); end
      if (e_valid[i]) begin
        total++; if (fif.pc !== e_pc[i]) begin bad++; $display("FAIL stream_pc[%0d]: got %h want %h", i, fif.pc, e_pc[i]); end
        total++; if (fif.pc_plus4 !== e_pc[i] + 32'd4) begin bad++; $display("FAIL stream_pc4[%0d]: got %h want %h", i, fif.pc_plus4, e_pc[i] + 32'd4); end
        total++; if (fif.inst !== word_of(e_pc[i])) begin bad++; $display("FAIL stream_inst[%0d]: got %h want %h", i, fif.inst, word_of(e_pc[i])); end
      end
    end
  endtask

  task automatic test_stall_skid;
    do_reset(1);
    repeat (5) @(negedge clk);
    total++; if (fif.inst_valid !== 1'b1 || fif.pc !== 32'h4) begin bad++; $display("FAIL stall_pre: got valid=%b pc=%h want valid=1 pc=00000004", fif.inst_valid, fif.pc); end
    fif.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (fif.inst_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, fif.inst_valid); end
      total++; if (fif.pc !== 32'h4) begin bad++; $display("FAIL stall_pc[%0d]: got %h want 00000004", i, fif.pc); end
      total++; if (fif.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req[%0d]: got %b want 0", i, fif.imem_req); end
    end
    fif.stall = 1'b0;
    @(negedge clk);
    total++; if (fif.inst_valid !== 1'b1) begin bad++; $display("FAIL skid_valid: got %b want 1", fif.inst_valid); end
    total++; if (fif.pc !== 32'h8) begin bad++; $display("FAIL skid_pc: got %h want 00000008", fif.pc); end
    total++; if (fif.pc_plus4 !== 32'hC) begin bad++; $display("FAIL skid_pc4: got %h want 0000000c", fif.pc_plus4); end
    total++; if (fif.inst !== word_of(32'h8)) begin bad++; $display("FAIL skid_inst: got %h want %h", fif.inst, word_of(32'h8)); end
    total++; if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'hC) begin bad++; $display("FAIL skid_next_req: got req=%b addr=%h want req=1 addr=0000000c", fif.imem_req, fif.imem_addr); end
  endtask

  task automatic test_redirect_wait;
    do_reset(3);
    @(negedge clk);
    total++; if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h0) begin bad++; $display("FAIL rdw_first_req: got req=%b addr=%h want req=1 addr=00000000", fif.imem_req, fif.imem_addr); end
    @(negedge clk);
    fif.redirect    = 1'b1;
    fif.redirect_pc = 32'h100;
    @(negedge clk);
    fif.redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (fif.imem_req !== 1'b0 || fif.inst_valid !== 1'b0) begin bad++; $display("FAIL rdw_drain[%0d]: got req=%b valid=%b want req=0 valid=0", i, fif.imem_req, fif.inst_valid); end
      @(negedge clk);
    end
    total++; if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h100) begin bad++; $display("FAIL rdw_new_req: got req=%b addr=%h want req=1 addr=00000100", fif.imem_req, fif.imem_addr); end
    total++; if (fif.inst_valid !== 1'b0) begin bad++; $display("FAIL rdw_flushed: got %b want 0", fif.inst_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (fif.inst_valid !== 1'b0) begin bad++; $display("FAIL rdw_wait_valid[%0d]: got %b want 0", i, fif.inst_valid); end
    end
    @(negedge clk);
    total++; if (fif.inst_valid !== 1'b1 || fif.pc !== 32'h100) begin bad++; $display("FAIL rdw_deliver: got valid=%b pc=%h want valid=1 pc=00000100", fif.inst_valid, fif.pc); end
    total++; if (fif.inst !== word_of(32'h100)) begin bad++; $display("FAIL rdw_inst: got %h want %h", fif.inst, word_of(32'h100)); end
    total++; if (fif.pc_plus4 !== 32'h104) begin bad++; $display("FAIL rdw_pc4: got %h want 00000104", fif.pc_plus4); end
  endtask

  task automatic test_redirect_rvalid_stall;
    do_reset(1);
    repeat (5) @(negedge clk);
    fif.stall = 1'b1;
    @(negedge clk);
    total++; if (fif.imem_rvalid !== 1'b1 || fif.inst_valid !== 1'b1) begin bad++; $display("FAIL rrs_setup: got rvalid=%b valid=%b want 1 1", fif.imem_rvalid, fif.inst_valid); end
    fif.redirect    = 1'b1;
    fif.redirect_pc = 32'h40;
    @(negedge clk);
    total++; if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h40) begin bad++; $display("FAIL rrs_req: got req=%b addr=%h want req=1 addr=00000040", fif.imem_req, fif.imem_addr); end
    total++; if (fif.inst_valid !== 1'b0) begin bad++; $display("FAIL rrs_flush: got %b want 0", fif.inst_valid); end
    fif.redirect = 1'b0;
    fif.stall    = 1'b0;
    @(negedge clk);
    total++; if (fif.inst_valid !== 1'b0) begin bad++; $display("FAIL rrs_gap: got %b want 0", fif.inst_valid); end
    @(negedge clk);
    total++; if (fif.inst_valid !== 1'b1 || fif.pc !== 32'h40 || fif.pc_plus4 !== 32'h44) begin bad++; $display("FAIL rrs_deliver: got valid=%b pc=%h pc4=%h want 1 00000040 00000044", fif.inst_valid, fif.pc, fif.pc_plus4); end
  endtask

  task automatic test_wrap;
    do_reset(1);
    @(negedge clk);
    fif.redirect    = 1'b1;
    fif.redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    fif.redirect = 1'b0;
    total++; if (fif.inst_valid !== 1'b0) begin bad++; $display("FAIL wrap_flush: got %b want 0", fif.inst_valid); end
    @(negedge clk);
    total++; if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req: got req=%b addr=%h want req=1 addr=fffffffc", fif.imem_req, fif.imem_addr); end
    repeat (2) @(negedge clk);
    total++; if (fif.inst_valid !== 1'b1 || fif.pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc: got valid=%b pc=%h want valid=1 pc=fffffffc", fif.inst_valid, fif.pc); end
    total++; if (fif.pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4: got %h want 00000000", fif.pc_plus4); end
    total++; if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next_addr: got req=%b addr=%h want req=1 addr=00000000", fif.imem_req, fif.imem_addr); end
  endtask

  task automatic test_misalign;
    do_reset(1);
    @(negedge clk);
    fif.redirect    = 1'b1;
    fif.redirect_pc = 32'h102;
    @(negedge clk);
    fif.redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    total++; if (fif.misalign !== 1'b1) begin bad++; $display("FAIL mis_set: got %b want 1", fif.misalign); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (fif.imem_req !== 1'b0 || fif.misalign !== 1'b1) begin bad++; $display("FAIL mis_idle[%0d]: got req=%b misalign=%b want req=0 misalign=1", i, fif.imem_req, fif.misalign); end
    end
    fif.redirect    = 1'b1;
    fif.redirect_pc = 32'h200;
    @(negedge clk);
    fif.redirect = 1'b0;
    total++; if (fif.misalign !== 1'b0) begin bad++; $display("FAIL mis_clear: got %b want 0", fif.misalign); end
    total++; if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h200) begin bad++; $display("FAIL mis_resume: got req=%b addr=%h want req=1 addr=00000200", fif.imem_req, fif.imem_addr); end
    repeat (2) @(negedge clk);
    total++; if (fif.inst_valid !== 1'b1 || fif.pc !== 32'h200) begin bad++; $display("FAIL mis_deliver: got valid=%b pc=%h want valid=1 pc=00000200", fif.inst_valid, fif.pc); end
`else
    total++; if (fif.misalign !== 1'b0) begin bad++; $display("FAIL mis_tied: got %b want 0", fif.misalign); end
    @(negedge clk);
    total++; if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h100) begin bad++; $display("FAIL mis_forced: got req=%b addr=%h want req=1 addr=00000100", fif.imem_req, fif.imem_addr); end
    repeat (2) @(negedge clk);
    total++; if (fif.inst_valid !== 1'b1 || fif.pc !== 32'h100) begin bad++; $display("FAIL mis_deliver: got valid=%b pc=%h want valid=1 pc=00000100", fif.inst_valid, fif.pc); end
    total++; if (fif.misalign !== 1'b0) begin bad++; $display("FAIL mis_tied_late: got %b want 0", fif.misalign); end
`endif
  endtask

  task automatic test_reset_midop;
    do_reset(1);
    repeat (3) @(negedge clk);
    total++; if (fif.inst_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre: got %b want 1", fif.inst_valid); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (fif.inst_valid !== 1'b0 || fif.inst !== 32'h13) begin bad++; $display("FAIL midrst_ifid: got valid=%b inst=%h want valid=0 inst=00000013", fif.inst_valid, fif.inst); end
    total++; if (fif.imem_req !== 1'b0 || fif.imem_addr !== 32'h0) begin bad++; $display("FAIL midrst_req: got req=%b addr=%h want req=0 addr=00000000", fif.imem_req, fif.imem_addr); end
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_stream();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_rvalid_stall();
    test_wrap();
    test_misalign();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
